// File: rtl/morse_encoder.sv
// ASCII-to-Morse symbol encoder: one character per valid/ready handshake,
// one registered symbol code per clock (WAIT/DIT/DAH/GAP/SPACE).
`timescale 1ns/1ps
module morse_encoder #(
  parameter int unsigned GAP_WAITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] letter,
  input  logic       letterValid,
  output logic       ready,
  output logic [2:0] inputSignal,
  output logic       err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_SPACE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  localparam logic [3:0] HOLD_LAST = 4'(GAP_WAITS - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] sig_q, sig_d;
  logic       err_q, err_d;
  logic [2:0] len_q, len_d;
  logic [4:0] pat_q, pat_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] hold_q, hold_d;

  logic [7:0] ch;
  logic [7:0] rom;
  logic [2:0] rom_len;
  logic [4:0] rom_pat;
  logic       rom_ok;

  // Pattern is right-aligned, first element in bit len-1; 1 = DAH.
  function automatic logic [2:0] elem(
    input logic [4:0] p,
    input logic [2:0] l,
    input logic [2:0] i
  );
    logic [2:0] k;
    k = l - 3'd1 - i;
    return p[k] ? SYM_DAH : SYM_DIT;
  endfunction

  always_comb begin
    ch = letter;
    if (letter >= 8'h61 && letter <= 8'h7A) ch = letter - 8'h20;
  end

  always_comb begin
    rom = 8'h00;
    case (ch)
      8'h41: rom = {3'd2, 5'b00001};
      8'h42: rom = {3'd4, 5'b01000};
      8'h43: rom = {3'd4, 5'b01010};
      8'h44: rom = {3'd3, 5'b00100};
      8'h45: rom = {3'd1, 5'b00000};
      8'h46: rom = {3'd4, 5'b00010};
      8'h47: rom = {3'd3, 5'b00110};
      8'h48: rom = {3'd4, 5'b00000};
      8'h49: rom = {3'd2, 5'b00000};
      8'h4A: rom = {3'd4, 5'b00111};
      8'h4B: rom = {3'd3, 5'b00101};
      8'h4C: rom = {3'd4, 5'b00100};
      8'h4D: rom = {3'd2, 5'b00011};
      8'h4E: rom = {3'd2, 5'b00010};
      8'h4F: rom = {3'd3, 5'b00111};
      8'h50: rom = {3'd4, 5'b00110};
      8'h51: rom = {3'd4, 5'b01101};
      8'h52: rom = {3'd3, 5'b00010};
      8'h53: rom = {3'd3, 5'b00000};
      8'h54: rom = {3'd1, 5'b00001};
      8'h55: rom = {3'd3, 5'b00001};
      8'h56: rom = {3'd4, 5'b00001};
      8'h57: rom = {3'd3, 5'b00011};
      8'h58: rom = {3'd4, 5'b01001};
      8'h59: rom = {3'd4, 5'b01011};
      8'h5A: rom = {3'd4, 5'b01100};
      8'h30: rom = {3'd5, 5'b11111};
      8'h31: rom = {3'd5, 5'b01111};
      8'h32: rom = {3'd5, 5'b00111};
      8'h33: rom = {3'd5, 5'b00011};
      8'h34: rom = {3'd5, 5'b00001};
      8'h35: rom = {3'd5, 5'b00000};
      8'h36: rom = {3'd5, 5'b10000};
      8'h37: rom = {3'd5, 5'b11000};
      8'h38: rom = {3'd5, 5'b11100};
      8'h39: rom = {3'd5, 5'b11110};
      default: rom = 8'h00;
    endcase
  end

  assign rom_len = rom[7:5];
  assign rom_pat = rom[4:0];
  assign rom_ok  = (rom_len != 3'd0);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    err_d   = 1'b0;
    len_d   = len_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        sig_d = SYM_WAIT;
        if (letterValid) begin
          if (letter == 8'h20) begin
            state_d = S_SPACE;
            sig_d   = SYM_SPACE;
          end else if (rom_ok) begin
            state_d = S_SEND;
            len_d   = rom_len;
            pat_d   = rom_pat;
            cnt_d   = 3'd0;
            sig_d   = elem(rom_pat, rom_len, 3'd0);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d = S_GAP;
          sig_d   = SYM_GAP;
        end else begin
          cnt_d = cnt_q + 3'd1;
          sig_d = elem(pat_q, len_q, cnt_q + 3'd1);
        end
      end
      S_GAP, S_SPACE: begin
        state_d = S_HOLD;
        hold_d  = 4'd0;
        sig_d   = SYM_WAIT;
      end
      S_HOLD: begin
        sig_d = SYM_WAIT;
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else hold_d = hold_q + 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        sig_d   = SYM_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sig_q   <= SYM_WAIT;
      err_q   <= 1'b0;
      len_q   <= 3'd0;
      pat_q   <= 5'd0;
      cnt_q   <= 3'd0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign inputSignal = sig_q;
  assign err         = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder: hand-computed symbol streams,
// handshake timing, unsupported characters and mid-character reset.
`timescale 1ns/1ps
module tb_morse_encoder;

  localparam logic [2:0] W  = 3'd0;
  localparam logic [2:0] DI = 3'd1;
  localparam logic [2:0] DA = 3'd2;
  localparam logic [2:0] GP = 3'd3;
  localparam logic [2:0] SP = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] letter = 8'h00;
  logic       letterValid = 1'b0;
  logic       ready;
  logic [2:0] inputSignal;
  logic       err;

  int checks = 0;
  int errors = 0;

  morse_encoder #(.GAP_WAITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .letter(letter),
    .letterValid(letterValid),
    .ready(ready),
    .inputSignal(inputSignal),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic step(input string tag, input logic [2:0] s,
                      input logic r, input logic e);
    chk({tag, ".sig"}, int'(inputSignal), int'(s));
    chk({tag, ".rdy"}, int'(ready), int'(r));
    chk({tag, ".err"}, int'(err), int'(e));
    tick();
  endtask

  task automatic accept(input logic [7:0] c);
    letter = c;
    letterValid = 1'b1;
    tick();
    letterValid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    step("reset", W, 1, 0);

    // 'E'
    accept(8'h45);
    step("E0", DI, 0, 0);
    step("E1", GP, 0, 0);
    step("E2", W, 0, 0);
    step("E3", W, 0, 0);
    step("E4", W, 1, 0);

    // 'B': ready low for exactly 7 cycles
    accept(8'h42);
    step("B0", DA, 0, 0);
    step("B1", DI, 0, 0);
    step("B2", DI, 0, 0);
    step("B3", DI, 0, 0);
    step("B4", GP, 0, 0);
    step("B5", W, 0, 0);
    step("B6", W, 0, 0);
    step("B7", W, 1, 0);

    // space then 'q' held valid
    letter = 8'h20;
    letterValid = 1'b1;
    tick();
    letter = 8'h71;
    step("S0", SP, 0, 0);
    step("S1", W, 0, 0);
    step("S2", W, 0, 0);
    step("S3", W, 1, 0);
    letterValid = 1'b0;
    letter = 8'h23;
    step("Q0", DA, 0, 0);
    step("Q1", DA, 0, 0);
    step("Q2", DI, 0, 0);
    step("Q3", DA, 0, 0);
    step("Q4", GP, 0, 0);
    step("Q5", W, 0, 0);
    step("Q6", W, 0, 0);
    step("Q7", W, 1, 0);

    // '0' then '5' back to back
    letter = 8'h30;
    letterValid = 1'b1;
    tick();
    letter = 8'h35;
    for (int i = 0; i < 5; i++) step("Z_dah", DA, 0, 0);
    step("Z_gap", GP, 0, 0);
    step("Z_w0", W, 0, 0);
    step("Z_w1", W, 0, 0);
    step("Z_idle", W, 1, 0);
    letterValid = 1'b0;
    for (int i = 0; i < 5; i++) step("F_dit", DI, 0, 0);
    step("F_gap", GP, 0, 0);
    step("F_w0", W, 0, 0);
    step("F_w1", W, 0, 0);
    step("F_idle", W, 1, 0);

    // unsupported '#'
    accept(8'h23);
    step("H0", W, 1, 1);
    step("H1", W, 1, 0);
    accept(8'h45);
    step("HE0", DI, 0, 0);
    step("HE1", GP, 0, 0);
    step("HE2", W, 0, 0);
    step("HE3", W, 0, 0);
    step("HE4", W, 1, 0);

    // reset during second element of 'B'; valid pulse in SEND ignored
    accept(8'h42);
    letter = 8'h45;
    letterValid = 1'b1;
    step("R0", DA, 0, 0);
    letterValid = 1'b0;
    chk("R1.sig", int'(inputSignal), int'(DI));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    step("R2", W, 1, 0);
    step("R3", W, 1, 0);
    step("R4", W, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Transmit-side counterpart of alphaFSM. It accepts one ASCII character at a time over a valid/ready handshake.
- It emits the matching Morse symbol stream as 3-bit codes, one per clock, in exactly the format alphaFSM consumes: WAIT=0, DIT=1, DAH=2, GAP=3, SPACE=4.
- Sits between the text source and the Morse symbol channel. In loopback, its symbol output drives alphaFSM.inputSignal directly.

Parameters:
- GAP_WAITS, 2, number of WAIT cycles emitted after each GAP or SPACE before the next character is accepted (legal range 1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- letter  input  8  ASCII character to encode.
- letterValid  input  1  letter is valid this cycle.
- ready  output  1  encoder is idle; a character is accepted on any rising edge where ready && letterValid.
- inputSignal  output  3  registered Morse symbol code (WAIT/DIT/DAH/GAP/SPACE).
- err  output  1  one-cycle pulse when an accepted character is unsupported.

Behaviour:
- Reset: state=IDLE, inputSignal=WAIT, ready=1, err=0. Reset has priority over every other event, including mid-character: the stream is abandoned and no GAP is emitted.
- Supported characters:
  - 'A'-'Z' (0x41-0x5A).
  - 'a'-'z' (0x61-0x7A), folded to uppercase.
  - '0'-'9' (0x30-0x39).
  - ' ' (0x20).
- Everything else is unsupported.
- Code ROM: combinational case on the folded character giving len[2:0] (1..5) and pat[4:0].
  - Element i (i=0 first) is DAH if pat[len-1-i]=1, else DIT.
  - Standard ITU table, e.g. E=DIT; B=DAH DIT DIT DIT; Q=DAH DAH DIT DAH; 0=DAH×5; 5=DIT×5.
- States:
  - IDLE: ready=1, inputSignal=WAIT.
    - Accepted letter: latch len/pat, go to SEND, element counter=0.
    - Accepted space: go to SPACE_S.
    - Accepted unsupported char: stay IDLE, err=1 next cycle only, ready stays 1.
  - SEND: ready=0; inputSignal = element[count], one element per cycle, no WAIT between elements. After element len-1, go to GAP_S.
  - GAP_S: inputSignal=GAP for one cycle; go to HOLD, hold counter=0.
  - SPACE_S: inputSignal=SPACE for one cycle; go to HOLD.
  - HOLD: inputSignal=WAIT for GAP_WAITS cycles, then IDLE.
- Latency: inputSignal is registered. The first element appears in the cycle right after the accepting edge.
- Occupancy: a character of length L occupies L+1+GAP_WAITS cycles after acceptance; a space occupies 1+GAP_WAITS cycles. ready rises the cycle after the last HOLD WAIT.
- letterValid while ready=0: ignored, not queued; the source must hold the letter until accepted.
- letter is sampled only on the accepting edge; later changes do not affect the character in flight.
- Back-to-back: if letterValid is held high, the next character is accepted on the first edge where ready=1. IDLE therefore lasts exactly one cycle between characters.
- Counters: element count 3 bits, hold count 4 bits; no wrap occurs within the legal GAP_WAITS range.

Test Plan:
- reset, then letter=0x45 'E' for one accept -> inputSignal sequence DIT, GAP, WAIT, WAIT, then ready=1; looped into alphaFSM gives done=1 and letter=69.
- 'B' (0x42) -> DAH, DIT, DIT, DIT, GAP, WAIT, WAIT; ready low for exactly 7 cycles after accept.
- 0x20, then 'q' (0x71) held valid -> SPACE, WAIT, WAIT, then one IDLE cycle, then DAH, DAH, DIT, DAH, GAP, WAIT, WAIT.
- '0' (0x30) then '5' (0x35) -> DAH×5, GAP, WAIT×2, then DIT×5, GAP, WAIT×2.
- '#' (0x23) -> err=1 for exactly one cycle, inputSignal stays WAIT, ready stays 1; a following 'E' encodes normally.
- reset asserted during the second element of 'B' -> next cycle inputSignal=WAIT, ready=1, err=0, no GAP emitted; letterValid pulsed during SEND is ignored.
